// File: rtl/falafel_pkg.sv
// falafel_pkg: shared allocator types, free-block layout and fit-search request/response types
package falafel_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NULL_PTR = '0;

    typedef struct packed {
        word_t size;
        word_t next_ptr;
    } free_block_t;

    typedef enum logic {
        FIT_FIRST,
        FIT_BEST
    } fit_mode_e;

    typedef struct packed {
        logic  found;
        logic  timeout;
        word_t ptr;
        word_t prev_ptr;
        word_t size;
    } fit_search_rsp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } fit_state_e;

endpackage

// File: rtl/falafel_fit_compare.sv
// falafel_fit_compare: per-hop evaluation of one free block against the request and the current best
module falafel_fit_compare
    import falafel_pkg::*;
(
    input  free_block_t block,
    input  word_t       req_size,
    input  word_t       best_size,
    input  logic        best_valid,
    input  fit_mode_e   mode,
    output logic        is_last,
    output logic        fits,
    output logic        is_better,
    output logic        is_exact
);

    assign is_last   = block.next_ptr == NULL_PTR;
    assign fits      = block.size >= req_size;
    assign is_exact  = block.size == req_size;
    // strict less-than so that ties keep the block seen earlier
    assign is_better = fits & ((mode == FIT_FIRST) | !best_valid | (block.size < best_size));

endmodule

// File: rtl/falafel_fit_searcher.sv
// falafel_fit_searcher: walks the free list one block per hop and returns the first or best fitting block
module falafel_fit_searcher
    import falafel_pkg::*;
#(
    parameter int MAX_HOPS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  word_t       req_head_ptr_i,
    input  word_t       req_size_i,
    input  fit_mode_e   req_mode_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output word_t       mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  free_block_t mem_rsp_block_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_found_o,
    output word_t       rsp_ptr_o,
    output word_t       rsp_prev_ptr_o,
    output word_t       rsp_size_o,
    output logic        rsp_timeout_o
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    fit_state_e       state_q, state_d;
    fit_mode_e        mode_q;
    word_t            size_q, cur_q, prev_q;
    word_t            best_ptr_q, best_prev_q, best_size_q;
    logic             best_valid_q;
    logic [HOP_W-1:0] hop_q, hop_nxt;
    free_block_t      blk_q;
    fit_search_rsp_t  rsp_q, eval_rsp;
    logic             is_last, fits, is_better, is_exact;
    logic             null_head, stop_hit, hop_limit, eval_done;

    falafel_fit_compare u_cmp (
        .block      (blk_q),
        .req_size   (size_q),
        .best_size  (best_size_q),
        .best_valid (best_valid_q),
        .mode       (mode_q),
        .is_last    (is_last),
        .fits       (fits),
        .is_better  (is_better),
        .is_exact   (is_exact)
    );

    assign null_head = req_head_ptr_i == NULL_PTR;
    assign hop_nxt   = hop_q + HOP_W'(1);
    assign stop_hit  = (mode_q == FIT_FIRST) ? fits : is_exact;
    assign hop_limit = hop_nxt == HOP_W'(MAX_HOPS);
    assign eval_done = stop_hit | is_last | hop_limit;

    assign req_ready_o     = state_q == S_IDLE;
    assign mem_req_valid_o = state_q == S_ISSUE;
    assign mem_req_addr_o  = cur_q;
    assign rsp_valid_o     = state_q == S_DONE;
    assign rsp_found_o     = rsp_q.found;
    assign rsp_timeout_o   = rsp_q.timeout;
    assign rsp_ptr_o       = rsp_q.ptr;
    assign rsp_prev_ptr_o  = rsp_q.prev_ptr;
    assign rsp_size_o      = rsp_q.size;

    // result of the hop being evaluated: immediate hit, best-so-far at list end, or timeout
    always_comb begin
        eval_rsp = '{found: 1'b0, timeout: 1'b0, ptr: NULL_PTR, prev_ptr: NULL_PTR, size: '0};
        if (stop_hit)
            eval_rsp = '{found: 1'b1, timeout: 1'b0, ptr: cur_q, prev_ptr: prev_q, size: blk_q.size};
        else if (is_last && is_better)
            eval_rsp = '{found: 1'b1, timeout: 1'b0, ptr: cur_q, prev_ptr: prev_q, size: blk_q.size};
        else if (is_last && best_valid_q)
            eval_rsp = '{found: 1'b1, timeout: 1'b0, ptr: best_ptr_q, prev_ptr: best_prev_q, size: best_size_q};
        else if (!is_last && hop_limit)
            eval_rsp.timeout = 1'b1;
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = !req_valid_i ? S_IDLE : (null_head ? S_DONE : S_ISSUE);
            S_ISSUE: state_d = mem_req_ready_i ? S_WAIT : S_ISSUE;
            S_WAIT:  state_d = mem_rsp_valid_i ? S_EVAL : S_WAIT;
            S_EVAL:  state_d = eval_done ? S_DONE : S_ISSUE;
            S_DONE:  state_d = rsp_ready_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // request latch, pointer walk, best tracking and result capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q       <= FIT_FIRST;
            size_q       <= '0;
            cur_q        <= NULL_PTR;
            prev_q       <= NULL_PTR;
            best_valid_q <= 1'b0;
            best_ptr_q   <= NULL_PTR;
            best_prev_q  <= NULL_PTR;
            best_size_q  <= '0;
            hop_q        <= '0;
            blk_q        <= '0;
            rsp_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid_i) begin
                    mode_q       <= req_mode_i;
                    size_q       <= req_size_i;
                    cur_q        <= req_head_ptr_i;
                    prev_q       <= NULL_PTR;
                    best_valid_q <= 1'b0;
                    best_ptr_q   <= NULL_PTR;
                    best_prev_q  <= NULL_PTR;
                    best_size_q  <= '0;
                    hop_q        <= '0;
                    rsp_q        <= '0;
                end
                S_WAIT: if (mem_rsp_valid_i) blk_q <= mem_rsp_block_i;
                S_EVAL: begin
                    hop_q <= hop_nxt;
                    if (is_better) begin
                        best_valid_q <= 1'b1;
                        best_ptr_q   <= cur_q;
                        best_prev_q  <= prev_q;
                        best_size_q  <= blk_q.size;
                    end
                    if (eval_done) begin
                        rsp_q <= eval_rsp;
                    end else begin
                        prev_q <= cur_q;
                        cur_q  <= blk_q.next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_falafel_fit_searcher.sv
// tb_falafel_fit_searcher: directed table plus randomized lists checked against a list-walk reference model
module tb_falafel_fit_searcher;
    import falafel_pkg::*;

    localparam int MAX_HOPS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    word_t       req_head_ptr_i = '0;
    word_t       req_size_i = '0;
    fit_mode_e   req_mode_i = FIT_FIRST;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    word_t       mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    free_block_t mem_rsp_block_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        rsp_found_o;
    word_t       rsp_ptr_o;
    word_t       rsp_prev_ptr_o;
    word_t       rsp_size_o;
    logic        rsp_timeout_o;

    falafel_fit_searcher #(.MAX_HOPS(MAX_HOPS)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_head_ptr_i  (req_head_ptr_i),
        .req_size_i      (req_size_i),
        .req_mode_i      (req_mode_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_block_i (mem_rsp_block_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_found_o     (rsp_found_o),
        .rsp_ptr_o       (rsp_ptr_o),
        .rsp_prev_ptr_o  (rsp_prev_ptr_o),
        .rsp_size_o      (rsp_size_o),
        .rsp_timeout_o   (rsp_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string     name;
        word_t     head;
        word_t     size;
        fit_mode_e mode;
        bit        stall;
        int        hold;
        bit        found;
        bit        timeout;
        word_t     ptr;
        word_t     prev;
        word_t     bsize;
        int        reads;
    } vec_t;

    free_block_t mem [word_t];
    int          checks = 0;
    int          failures = 0;
    int          reads = 0;
    bit          stall_en = 0;
    int          rsp_delay = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    free_block_t pend_blk;
    bit          stalled = 0;
    word_t       stall_addr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input word_t head, input word_t size, input fit_mode_e mode,
                                input bit stall, input int hold, input bit found, input bit timeout,
                                input word_t ptr, input word_t prev, input word_t bsize, input int rd);
        vec_t v;
        v.name = name; v.head = head; v.size = size; v.mode = mode; v.stall = stall; v.hold = hold;
        v.found = found; v.timeout = timeout; v.ptr = ptr; v.prev = prev; v.bsize = bsize; v.reads = rd;
        return v;
    endfunction

    // reference: materialise the visited prefix of the list, then pick the answer from it
    function automatic vec_t model(input string name, input word_t head, input word_t size, input fit_mode_e mode);
        vec_t  e;
        word_t path [$];
        word_t cur = head;
        int    hit = -1;
        bit    exact = 0;
        bit    term;
        e = mk(name, head, size, mode, 0, 0, 0, 0, NULL_PTR, NULL_PTR, 0, 0);
        while (cur != NULL_PTR && path.size() < MAX_HOPS) begin
            path.push_back(cur);
            cur = mem[cur].next_ptr;
        end
        term = cur == NULL_PTR;
        if (mode == FIT_FIRST) begin
            for (int i = 0; i < path.size(); i++)
                if (hit < 0 && mem[path[i]].size >= size) hit = i;
        end else begin
            for (int i = 0; i < path.size(); i++)
                if (hit < 0 && mem[path[i]].size == size) hit = i;
            exact = hit >= 0;
            if (!exact && term)
                for (int i = 0; i < path.size(); i++)
                    if (mem[path[i]].size >= size && (hit < 0 || mem[path[i]].size < mem[path[hit]].size)) hit = i;
        end
        if (hit >= 0) begin
            e.found = 1;
            e.ptr   = path[hit];
            e.prev  = hit == 0 ? NULL_PTR : path[hit-1];
            e.bsize = mem[path[hit]].size;
            e.reads = (mode == FIT_FIRST || exact) ? hit + 1 : path.size();
        end else begin
            e.reads   = path.size();
            e.timeout = !term;
        end
        return e;
    endfunction

    // memory responder: random or fixed accept/response timing, one read in flight
    initial begin
        forever begin
            @(negedge clk_i);
            mem_rsp_valid_i = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_block_i = pend_blk;
                    pend = 0;
                end else pend_cnt--;
            end
            if (stalled && mem_req_valid_o) chk("mem_addr_stable", mem_req_addr_o, stall_addr);
            stalled = 0;
            mem_req_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_req_valid_o && !rst_i) begin
                if (!mem_req_ready_i) begin
                    stalled = 1;
                    stall_addr = mem_req_addr_o;
                end else begin
                    pend = 1;
                    pend_cnt = stall_en ? int'($urandom_range(0, 3)) : rsp_delay;
                    pend_blk = mem.exists(mem_req_addr_o) ? mem[mem_req_addr_o] : '0;
                    reads++;
                end
            end
        end
    end

    task automatic run(input vec_t v);
        int    n = 0;
        bit    stable = 1;
        logic  g_found, g_to;
        word_t g_ptr, g_prev, g_size;
        stall_en = v.stall;
        @(negedge clk_i);
        chk($sformatf("%s_req_ready", v.name), req_ready_o, 1);
        reads = 0;
        req_valid_i = 1'b1;
        req_head_ptr_i = v.head;
        req_size_i = v.size;
        req_mode_i = v.mode;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        while (!rsp_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (!rsp_valid_o) begin
            chk($sformatf("%s_rsp_arrived", v.name), 0, 1);
            rst_i = 1'b1;
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0;
            return;
        end
        g_found = rsp_found_o; g_to = rsp_timeout_o;
        g_ptr = rsp_ptr_o; g_prev = rsp_prev_ptr_o; g_size = rsp_size_o;
        repeat (v.hold) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_found_o !== g_found || rsp_timeout_o !== g_to ||
                rsp_ptr_o !== g_ptr || rsp_prev_ptr_o !== g_prev || rsp_size_o !== g_size) stable = 0;
        end
        if (v.hold > 0) chk($sformatf("%s_rsp_held", v.name), stable, 1);
        chk($sformatf("%s_found", v.name), g_found, v.found);
        chk($sformatf("%s_timeout", v.name), g_to, v.timeout);
        chk($sformatf("%s_ptr", v.name), g_ptr, v.ptr);
        chk($sformatf("%s_prev", v.name), g_prev, v.prev);
        chk($sformatf("%s_size", v.name), g_size, v.bsize);
        chk($sformatf("%s_reads", v.name), reads, v.reads);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk($sformatf("%s_back_idle", v.name), {rsp_valid_o, req_ready_o}, 2'b01);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t tab [11];
        vec_t e;
        bit   ok;
        word_t addrs [6];
        tab[0]  = mk("A_first_24",   32'h100, 24,  FIT_FIRST, 0, 0, 1, 0, 32'h200, 32'h100, 64, 2);
        tab[1]  = mk("A_best_24",    32'h100, 24,  FIT_BEST,  0, 0, 1, 0, 32'h300, 32'h200, 32, 3);
        tab[2]  = mk("A_best_64",    32'h100, 64,  FIT_BEST,  0, 0, 1, 0, 32'h200, 32'h100, 64, 2);
        tab[3]  = mk("A_first_128",  32'h100, 128, FIT_FIRST, 0, 0, 0, 0, 0, 0, 0, 3);
        tab[4]  = mk("null_head",    32'h0,   8,   FIT_FIRST, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[5]  = mk("loop_first",   32'h400, 16,  FIT_FIRST, 0, 0, 0, 1, 0, 0, 0, 4);
        tab[6]  = mk("A_first_0",    32'h100, 0,   FIT_FIRST, 0, 0, 1, 0, 32'h100, 0, 16, 1);
        tab[7]  = mk("A_best_0",     32'h100, 0,   FIT_BEST,  0, 0, 1, 0, 32'h100, 0, 16, 3);
        tab[8]  = mk("A_best_stall", 32'h100, 24,  FIT_BEST,  1, 5, 1, 0, 32'h300, 32'h200, 32, 3);
        tab[9]  = mk("loop_best",    32'h400, 16,  FIT_BEST,  1, 5, 0, 1, 0, 0, 0, 4);
        tab[10] = mk("loop_best_8",  32'h400, 8,   FIT_BEST,  0, 2, 1, 0, 32'h400, 0, 8, 1);
        mem[32'h100] = '{size: 16, next_ptr: 32'h200};
        mem[32'h200] = '{size: 64, next_ptr: 32'h300};
        mem[32'h300] = '{size: 32, next_ptr: NULL_PTR};
        mem[32'h400] = '{size: 8,  next_ptr: 32'h400};

        repeat (3) @(negedge clk_i);
        chk("reset_ready", req_ready_o, 1);
        chk("reset_mem_valid", mem_req_valid_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_data", {rsp_found_o, rsp_timeout_o, rsp_ptr_o, rsp_prev_ptr_o, rsp_size_o[29:0]}, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) run(tab[i]);

        stall_en = 0;
        rsp_delay = 3;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_head_ptr_i = 32'h100;
        req_size_i = 24;
        req_mode_i = FIT_FIRST;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        ok = 1;
        repeat (6) begin
            @(negedge clk_i);
            if (rsp_valid_o || !req_ready_o || mem_req_valid_o) ok = 0;
        end
        chk("rst_in_wait_idle", ok, 1);
        rsp_delay = 0;
        run(tab[0]);

        for (int t = 0; t < 60; t++) begin
            int n = $urandom_range(1, 6);
            mem.delete();
            for (int i = 0; i < 6; i++) addrs[i] = 32'h1000 + 32'(i) * 32'h40;
            for (int i = 5; i > 0; i--) begin
                int j = $urandom_range(0, i);
                word_t tmp = addrs[i];
                addrs[i] = addrs[j];
                addrs[j] = tmp;
            end
            for (int i = 0; i < n; i++)
                mem[addrs[i]] = '{size: 32'($urandom_range(0, 8)),
                                  next_ptr: (i < n - 1) ? addrs[i+1]
                                          : ($urandom_range(0, 3) == 0 ? addrs[$urandom_range(0, n - 1)] : NULL_PTR)};
            e = model($sformatf("rand%0d", t), addrs[0], 32'($urandom_range(0, 9)),
                      $urandom_range(0, 1) ? FIT_BEST : FIT_FIRST);
            e.stall = 1'($urandom_range(0, 1));
            e.hold = $urandom_range(0, 5);
            run(e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
